// File: rtl/wt_cache_pkg.sv
// Shared write-through cache definitions: geometry plus SHiP predictor types.
package wt_cache_pkg;

   localparam int unsigned DCACHE_CL_IDX_WIDTH = 4;
   localparam int unsigned DCACHE_SET_ASSOC    = 4;
   localparam int unsigned DCACHE_NUM_SETS     = 2**DCACHE_CL_IDX_WIDTH;
   localparam int unsigned DCACHE_WAY_W        = $clog2(DCACHE_SET_ASSOC);

   // SHiP signature and counter widths; the structs below are sized from these
   localparam int unsigned SHIP_SIG_W = 6;
   localparam int unsigned SHIP_CTR_W = 3;

   typedef logic [SHIP_SIG_W-1:0] ship_sig_t;

   // per-line outcome metadata
   typedef struct packed {
      logic      valid;
      ship_sig_t sig;
      logic      reused;
   } ship_line_meta_t;

   // one cycle of pending SHCT training
   typedef struct packed {
      logic      inc_v;
      ship_sig_t inc_sig;
      logic      dec_v;
      ship_sig_t dec_sig;
   } ship_train_t;

   typedef enum logic [0:0] {
      SHIP_IDLE  = 1'b0,
      SHIP_CLEAR = 1'b1
   } ship_state_e;

endpackage

// File: rtl/wt_dcache_shct.sv
// Signature hit counter table: saturating counters with inc/dec/sweep writes
// and a read port that already reflects the training applied this cycle.
module wt_dcache_shct
   import wt_cache_pkg::*;
#(
   parameter int unsigned SIG_W    = SHIP_SIG_W,
   parameter int unsigned CTR_W    = SHIP_CTR_W,
   parameter int unsigned CTR_INIT = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [SIG_W-1:0] rd_sig_i,
   output logic [CTR_W-1:0] rd_ctr_o,
   input  logic             inc_v_i,
   input  logic [SIG_W-1:0] inc_sig_i,
   input  logic             dec_v_i,
   input  logic [SIG_W-1:0] dec_sig_i,
   input  logic             sweep_we_i,
   input  logic [SIG_W-1:0] sweep_ptr_i
);

   localparam int unsigned      DEPTH   = 2**SIG_W;
   localparam logic [CTR_W-1:0] CTR_MAX = '1;
   localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(CTR_INIT);

   logic [CTR_W-1:0] ctr_q [DEPTH];
   logic [CTR_W-1:0] ctr_d [DEPTH];

   // saturating step; inc and dec together cancel
   function automatic logic [CTR_W-1:0] ctr_step(input logic [CTR_W-1:0] c,
                                                 input logic inc, input logic dec);
      if (inc && !dec && c != CTR_MAX) return c + 1'b1;
      if (dec && !inc && c != '0)      return c - 1'b1;
      return c;
   endfunction

   // read bypass: the value this entry will hold after the pending update
   always_comb begin
      rd_ctr_o = ctr_step(ctr_q[rd_sig_i],
                          inc_v_i && (inc_sig_i == rd_sig_i),
                          dec_v_i && (dec_sig_i == rd_sig_i));
   end

   // next table state: training per entry, sweep write overrides
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ctr_d[i] = ctr_step(ctr_q[i],
                             inc_v_i && (inc_sig_i == SIG_W'(i)),
                             dec_v_i && (dec_sig_i == SIG_W'(i)));
         if (sweep_we_i && (sweep_ptr_i == SIG_W'(i))) ctr_d[i] = CTR_RST;
      end
   end

   // counter storage
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_RST;
      end else begin
         for (int i = 0; i < DEPTH; i++) ctr_q[i] <= ctr_d[i];
      end
   end

endmodule

// File: rtl/wt_dcache_ship_pred.sv
// SHiP insertion predictor for the write-through dcache SRRIP stage.
// Holds the PC hash, per-line metadata, training register and flush sweep FSM.
// Optional statistics outputs: define WT_DCACHE_SHIP_STATS_EN.
// SIG_W/CTR_W must match SHIP_SIG_W/SHIP_CTR_W, which size the shared structs.
module wt_dcache_ship_pred
   import wt_cache_pkg::*;
#(
   parameter int unsigned SIG_W    = SHIP_SIG_W,
   parameter int unsigned CTR_W    = SHIP_CTR_W,
   parameter int unsigned CTR_INIT = 1,
   parameter int unsigned PC_W     = 64
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           flush_i,
   input  logic                           miss_i,
   input  logic [DCACHE_CL_IDX_WIDTH-1:0] miss_idx_i,
   input  logic [PC_W-1:0]                miss_pc_i,
   input  logic [DCACHE_WAY_W-1:0]        fill_way_i,
   input  logic                           hit_i,
   input  logic [DCACHE_CL_IDX_WIDTH-1:0] hit_idx_i,
   input  logic [DCACHE_WAY_W-1:0]        hit_way_i,
   output logic [1:0]                     pred_result_o,
   output logic                           busy_o
`ifdef WT_DCACHE_SHIP_STATS_EN
   ,
   output logic [31:0]                    stat_pred_near_o,
   output logic [31:0]                    stat_pred_dist_o,
   output logic [31:0]                    stat_evict_dead_o
`endif
);

   localparam logic [CTR_W-1:0] CTR_MAX  = '1;
   localparam logic [SIG_W-1:0] PTR_LAST = '1;

   ship_state_e      state_q, state_d;
   logic [SIG_W-1:0] ptr_q, ptr_d;
   logic             sweep_we;

   ship_line_meta_t  meta_q [DCACHE_NUM_SETS][DCACHE_SET_ASSOC];
   ship_line_meta_t  meta_d [DCACHE_NUM_SETS][DCACHE_SET_ASSOC];
   ship_train_t      train_q, train_d;
   ship_line_meta_t  victim, hline;
   logic             same_line, train_en;

   logic [SIG_W-1:0] miss_sig;
   logic [CTR_W-1:0] ctr_byp;
   logic             unused_pc_bits;

   assign miss_sig       = miss_pc_i[SIG_W+1:2] ^ miss_pc_i[2*SIG_W+1:SIG_W+2];
   assign unused_pc_bits = ^{miss_pc_i[PC_W-1:2*SIG_W+2], miss_pc_i[1:0]};

   // a training update still in flight on the flush cycle is discarded
   assign train_en = (state_q == SHIP_IDLE) && !flush_i;

   wt_dcache_shct #(.SIG_W(SIG_W), .CTR_W(CTR_W), .CTR_INIT(CTR_INIT)) u_shct (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .rd_sig_i    (miss_sig),
      .rd_ctr_o    (ctr_byp),
      .inc_v_i     (train_q.inc_v && train_en),
      .inc_sig_i   (train_q.inc_sig),
      .dec_v_i     (train_q.dec_v && train_en),
      .dec_sig_i   (train_q.dec_sig),
      .sweep_we_i  (sweep_we),
      .sweep_ptr_i (ptr_q)
   );

   // sweep FSM state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= SHIP_IDLE;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // sweep FSM next state: a flush always (re)starts the sweep at entry 0
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         SHIP_IDLE: begin
            if (flush_i) begin
               state_d = SHIP_CLEAR;
               ptr_d   = '0;
            end
         end
         SHIP_CLEAR: begin
            if (flush_i) begin
               ptr_d = '0;
            end else if (ptr_q == PTR_LAST) begin
               state_d = SHIP_IDLE;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end
         default: state_d = SHIP_IDLE;
      endcase
   end

   // sweep FSM outputs
   always_comb begin
      busy_o   = (state_q == SHIP_CLEAR);
      sweep_we = (state_q == SHIP_CLEAR);
   end

   // prediction from the bypassed counter; neutral while the table is rebuilt
   always_comb begin
      if (busy_o)                 pred_result_o = 2'd2;
      else if (ctr_byp == '0)     pred_result_o = 2'd3;
      else if (ctr_byp == CTR_MAX) pred_result_o = 2'd0;
      else                        pred_result_o = 2'd2;
   end

   // line metadata update and training capture; a miss shadows a hit to its own line
   always_comb begin
      meta_d    = meta_q;
      train_d   = '0;
      victim    = meta_q[miss_idx_i][fill_way_i];
      hline     = meta_q[hit_idx_i][hit_way_i];
      same_line = miss_i && (miss_idx_i == hit_idx_i) && (fill_way_i == hit_way_i);
      if (flush_i) begin
         for (int s = 0; s < DCACHE_NUM_SETS; s++) begin
            for (int w = 0; w < DCACHE_SET_ASSOC; w++) begin
               meta_d[s][w].valid  = 1'b0;
               meta_d[s][w].reused = 1'b0;
            end
         end
      end
      if (miss_i) begin
         meta_d[miss_idx_i][fill_way_i] = '{valid: 1'b1, sig: miss_sig, reused: 1'b0};
         train_d.dec_v   = victim.valid && !victim.reused;
         train_d.dec_sig = victim.sig;
      end
      if (hit_i && !same_line && !flush_i && hline.valid && !hline.reused) begin
         meta_d[hit_idx_i][hit_way_i].reused = 1'b1;
         train_d.inc_v   = 1'b1;
         train_d.inc_sig = hline.sig;
      end
      if (flush_i || state_q != SHIP_IDLE) train_d = '0;
   end

   // metadata and training register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int s = 0; s < DCACHE_NUM_SETS; s++) begin
            for (int w = 0; w < DCACHE_SET_ASSOC; w++) meta_q[s][w] <= '0;
         end
         train_q <= '0;
      end else begin
         meta_q  <= meta_d;
         train_q <= train_d;
      end
   end

`ifdef WT_DCACHE_SHIP_STATS_EN
   logic [31:0] near_q, near_d, dist_q, dist_d, dead_q, dead_d;

   // saturating event counters, cleared only by reset
   always_comb begin
      near_d = near_q;
      dist_d = dist_q;
      dead_d = dead_q;
      if (miss_i && pred_result_o == 2'd0 && near_q != '1) near_d = near_q + 32'd1;
      if (miss_i && pred_result_o == 2'd3 && dist_q != '1) dist_d = dist_q + 32'd1;
      if (train_d.dec_v && dead_q != '1)                   dead_d = dead_q + 32'd1;
   end

   // statistics registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         near_q <= '0;
         dist_q <= '0;
         dead_q <= '0;
      end else begin
         near_q <= near_d;
         dist_q <= dist_d;
         dead_q <= dead_d;
      end
   end

   assign stat_pred_near_o  = near_q;
   assign stat_pred_dist_o  = dist_q;
   assign stat_evict_dead_o = dead_q;
`endif

endmodule
